// File: rtl/merge_input_fifo.sv
// First-word-fall-through record FIFO feeding one side of a merge stage.
// Tracks stored end-of-run terminators (zero records) and sticky over/underflow errors.
module merge_input_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AF_MARGIN = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    input  logic                     i_rd_en,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_almost_full,
    output logic                     o_min_zero,
    output logic                     o_r_min_zero,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_run_avail,
    output logic [1:0]               o_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     count;
    logic [PW-1:0]     run_cnt;
    logic              r_min_zero;
    logic [1:0]        err;

    logic              empty;
    logic              full;
    logic              wr_acc;
    logic              rd_acc;
    logic              head_zero;
    logic              wr_term;
    logic              rd_term;

    // Extra wrap bit distinguishes full from empty when addresses coincide.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_acc    = i_wr_en && !full;
    assign rd_acc    = i_rd_en && !empty;
    assign o_head    = mem[rd_ptr[AW-1:0]];
    assign head_zero = (o_head == '0);
    assign wr_term   = wr_acc && (i_wr_data == '0);
    assign rd_term   = rd_acc && head_zero;

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            run_cnt    <= '0;
            r_min_zero <= 1'b0;
            err        <= 2'b00;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr     <= rd_ptr + PW'(1);
                r_min_zero <= head_zero;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + PW'(1);
                2'b01:   count <= count - PW'(1);
                default: count <= count;
            endcase
            case ({wr_term, rd_term})
                2'b10:   run_cnt <= run_cnt + PW'(1);
                2'b01:   run_cnt <= run_cnt - PW'(1);
                default: run_cnt <= run_cnt;
            endcase
            if (i_wr_en && full) begin
                err[0] <= 1'b1;
            end
            if (i_rd_en && empty) begin
                err[1] <= 1'b1;
            end
        end
    end

    assign o_empty       = empty;
    assign o_full        = full;
    assign o_count       = count;
    assign o_almost_full = (count >= PW'(DEPTH - AF_MARGIN));
    assign o_min_zero    = !empty && head_zero;
    assign o_r_min_zero  = r_min_zero;
    assign o_run_avail   = (run_cnt != '0);
    assign o_err         = err;

endmodule

// File: tb/tb_merge_input_fifo.sv
// Directed bench for merge_input_fifo: terminator vector table plus fill,
// simultaneous-access, wrap and asynchronous-reset sequences.
module tb_merge_input_fifo;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] head;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic        min_zero;
    logic        r_min_zero;
    logic [4:0]  count;
    logic        run_avail;
    logic [1:0]  err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    merge_input_fifo #(.DATA_W(32), .DEPTH(16), .AF_MARGIN(2)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_wr_en       (wr_en),
        .i_wr_data     (wr_data),
        .i_rd_en       (rd_en),
        .o_head        (head),
        .o_empty       (empty),
        .o_full        (full),
        .o_almost_full (almost_full),
        .o_min_zero    (min_zero),
        .o_r_min_zero  (r_min_zero),
        .o_count       (count),
        .o_run_avail   (run_avail),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic        rd;
        int          cnt;
        logic        emp;
        logic [31:0] hd;
        logic        mz;
        logic        rmz;
        logic        run;
    } vec_t;

    vec_t tv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r);
        @(negedge clk);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
    endtask

    logic [31:0] q [$];
    logic [31:0] nextv;
    logic        dw;
    logic        dr;

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;

        tv[0] = '{1'b1, 32'd5, 1'b0, 1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0};
        tv[1] = '{1'b1, 32'd7, 1'b0, 2, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0};
        tv[2] = '{1'b1, 32'd0, 1'b0, 3, 1'b0, 32'd5, 1'b0, 1'b0, 1'b1};
        tv[3] = '{1'b1, 32'd3, 1'b0, 4, 1'b0, 32'd5, 1'b0, 1'b0, 1'b1};
        tv[4] = '{1'b1, 32'd0, 1'b0, 5, 1'b0, 32'd5, 1'b0, 1'b0, 1'b1};
        tv[5] = '{1'b0, 32'd0, 1'b1, 4, 1'b0, 32'd7, 1'b0, 1'b0, 1'b1};
        tv[6] = '{1'b0, 32'd0, 1'b1, 3, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tv[7] = '{1'b0, 32'd0, 1'b1, 2, 1'b0, 32'd3, 1'b0, 1'b1, 1'b1};
        tv[8] = '{1'b0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b1};
        tv[9] = '{1'b0, 32'd0, 1'b1, 0, 1'b1, 32'd0, 1'b0, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_af", 32'(almost_full), 0);
        chk("rst_mz", 32'(min_zero), 0);
        chk("rst_rmz", 32'(r_min_zero), 0);
        chk("rst_run", 32'(run_avail), 0);
        chk("rst_err", 32'(err), 0);

        // Terminator sequence
        for (int i = 0; i < 10; i++) begin
            step(tv[i].wr, tv[i].data, tv[i].rd);
            chk($sformatf("term%0d_count", i), 32'(count), 32'(tv[i].cnt));
            chk($sformatf("term%0d_empty", i), 32'(empty), 32'(tv[i].emp));
            if (!tv[i].emp) chk($sformatf("term%0d_head", i), head, tv[i].hd);
            chk($sformatf("term%0d_mz", i), 32'(min_zero), 32'(tv[i].mz));
            chk($sformatf("term%0d_rmz", i), 32'(r_min_zero), 32'(tv[i].rmz));
            chk($sformatf("term%0d_run", i), 32'(run_avail), 32'(tv[i].run));
            chk($sformatf("term%0d_err", i), 32'(err), 0);
        end

        // Fill test
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 32'(i), 1'b0);
            chk($sformatf("fill%0d_count", i), 32'(count), 32'(i));
            chk($sformatf("fill%0d_af", i), 32'(almost_full), 32'(i >= 14));
            chk($sformatf("fill%0d_full", i), 32'(full), 32'(i == 16));
        end
        step(1'b1, 32'd77, 1'b0);
        chk("ovf_count", 32'(count), 16);
        chk("ovf_err", 32'(err), 1);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain%0d_head", i), head, 32'(i));
            step(1'b0, 32'd0, 1'b1);
        end
        chk("drain_empty", 32'(empty), 1);
        chk("drain_count", 32'(count), 0);

        // Simultaneous read+write at full: read wins, write rejected
        do_reset();
        for (int i = 1; i <= 16; i++) step(1'b1, 32'(i), 1'b0);
        chk("sim_full_pre", 32'(full), 1);
        step(1'b1, 32'd99, 1'b1);
        chk("sim_full_count", 32'(count), 15);
        chk("sim_full_head", head, 2);
        chk("sim_full_err", 32'(err), 1);
        for (int i = 2; i <= 16; i++) begin
            chk($sformatf("sim_drain%0d", i), head, 32'(i));
            step(1'b0, 32'd0, 1'b1);
        end
        chk("sim_drain_empty", 32'(empty), 1);
        // Simultaneous at empty: write wins, underflow flagged
        step(1'b1, 32'd42, 1'b1);
        chk("sim_empty_count", 32'(count), 1);
        chk("sim_empty_head", head, 42);
        chk("sim_empty_err", 32'(err), 3);

        // Wrap test: count held at 2..3, more than 2*DEPTH writes
        do_reset();
        q.delete();
        nextv = 1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, nextv, 1'b0);
            q.push_back(nextv);
            nextv++;
        end
        for (int k = 0; k < 48; k++) begin
            dw = (k % 4 != 3);
            dr = (k % 4 != 1);
            if (dr) chk($sformatf("wrap%0d_head", k), head, q[0]);
            step(dw, nextv, dr);
            if (dw) begin
                q.push_back(nextv);
                nextv++;
            end
            if (dr) void'(q.pop_front());
            chk($sformatf("wrap%0d_count", k), 32'(count), 32'(q.size()));
            chk($sformatf("wrap%0d_full", k), 32'(full), 0);
        end
        chk("wrap_err", 32'(err), 0);

        // Asynchronous reset mid-operation
        do_reset();
        step(1'b0, 32'd0, 1'b1);
        chk("ar_err_pre", 32'(err), 2);
        for (int i = 0; i < 3; i++) step(1'b1, 32'd0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 32'(i + 10), 1'b0);
        step(1'b0, 32'd0, 1'b1);
        chk("ar_count_pre", 32'(count), 9);
        chk("ar_rmz_pre", 32'(r_min_zero), 1);
        chk("ar_run_pre", 32'(run_avail), 1);
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(count), 0);
        chk("ar_empty", 32'(empty), 1);
        chk("ar_full", 32'(full), 0);
        chk("ar_af", 32'(almost_full), 0);
        chk("ar_mz", 32'(min_zero), 0);
        chk("ar_rmz", 32'(r_min_zero), 0);
        chk("ar_run", 32'(run_avail), 0);
        chk("ar_err", 32'(err), 0);
        #1;
        rst = 1'b0;
        step(1'b1, 32'd0, 1'b0);
        chk("ar_post_mz", 32'(min_zero), 1);
        chk("ar_post_count", 32'(count), 1);
        chk("ar_post_run", 32'(run_avail), 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
